// File: rtl/iccm_fetch_master_if.sv
// iccm_fetch_master_if: fetch request/response and AXI4 read-channel bundle.
interface iccm_fetch_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              rsp_err;
   logic              busy;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [1:0]        m_axi_arburst;
   logic [ID_W-1:0]   m_axi_arid;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [ID_W-1:0]   m_axi_rid;
   logic              m_axi_rlast;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rvalid;
   logic              m_axi_rready;
   modport master (
      input  req_valid, req_addr, rsp_ready, m_axi_arready, m_axi_rdata, m_axi_rid,
             m_axi_rlast, m_axi_rresp, m_axi_rvalid,
      output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy, m_axi_araddr,
             m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid, m_axi_rready
   );
   modport slave (
      output req_valid, req_addr, rsp_ready, m_axi_arready, m_axi_rdata, m_axi_rid,
             m_axi_rlast, m_axi_rresp, m_axi_rvalid,
      input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy, m_axi_araddr,
             m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid, m_axi_rready
   );
endinterface

// File: rtl/iccm_fetch_master.sv
// iccm_fetch_master: fetches one ICCM line per request as an AXI4 INCR burst and streams it out
// through a 2-entry skid FIFO.
module iccm_fetch_master #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4,
   parameter int LINE_WORDS = 8,
   parameter int AXI_ID     = 0
) (
   input logic                aclk_i,
   input logic                areset_i,
   iccm_fetch_master_if.master bus
);
   localparam int CW  = $clog2(LINE_WORDS);
   localparam int OFF = $clog2(LINE_WORDS * 4);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                wr_q, wr_d, rd_q, rd_d;
   logic [1:0]          fcnt_q, fcnt_d;
   logic [DATA_W+1:0]   mem_q [2];
   logic                push, pop, last_beat, beat_err;
   // Beat position comes from our own counter; the slave's rlast is only cross-checked.
   assign last_beat = cnt_q == CW'(LINE_WORDS - 1);
   assign beat_err  = (bus.m_axi_rresp != 2'b00) | (bus.m_axi_rid != ID_W'(AXI_ID)) |
                      (bus.m_axi_rlast != last_beat);
   assign push      = bus.m_axi_rvalid & bus.m_axi_rready;
   assign pop       = bus.rsp_valid & bus.rsp_ready;
   always_ff @(posedge aclk_i or posedge areset_i) begin
      if (areset_i) state_q <= IDLE;
      else          state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE && bus.req_valid)            ? ADDR :
                (state_q == ADDR && bus.m_axi_arready)        ? DATA :
                (state_q == DATA && pop && bus.rsp_last)      ? IDLE : state_q;
   end
   always_comb begin
      bus.req_ready     = state_q == IDLE;
      bus.busy          = state_q != IDLE;
      bus.m_axi_arvalid = state_q == ADDR;
      bus.m_axi_rready  = (state_q == DATA) & ~done_q & (fcnt_q != 2'd2);
      bus.m_axi_araddr  = araddr_q;
      bus.m_axi_arburst = 2'b01;
      bus.m_axi_arid    = ID_W'(AXI_ID);
      bus.m_axi_arlen   = 8'(LINE_WORDS - 1);
      bus.m_axi_arsize  = 3'b010;
      bus.rsp_valid     = fcnt_q != 2'd0;
      bus.rsp_data      = mem_q[rd_q][DATA_W+1:2];
      bus.rsp_last      = bus.rsp_valid & mem_q[rd_q][1];
      bus.rsp_err       = bus.rsp_valid & mem_q[rd_q][0];
   end
   always_comb begin
      araddr_d = (state_q == IDLE && bus.req_valid) ?
                 {bus.req_addr[ADDR_W-1:OFF], {OFF{1'b0}}} : araddr_q;
      cnt_d    = (state_q == ADDR) ? '0 : push ? cnt_q + 1'b1 : cnt_q;
      done_d   = (state_q == ADDR) ? 1'b0 : (push && last_beat) ? 1'b1 : done_q;
      wr_d     = wr_q ^ push;
      rd_d     = rd_q ^ pop;
      fcnt_d   = fcnt_q + {1'b0, push} - {1'b0, pop};
   end
   always_ff @(posedge aclk_i or posedge areset_i) begin
      if (areset_i) begin
         araddr_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         fcnt_q   <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         araddr_q <= araddr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         fcnt_q   <= fcnt_d;
         if (push) mem_q[wr_q] <= {bus.m_axi_rdata, last_beat, beat_err};
      end
   end
endmodule

// File: tb/tb_iccm_fetch_master.sv
// tb_iccm_fetch_master: randomized fetch traffic against a queue-based line model with an
// in-bench ICCM slave that can stall, corrupt responses and misplace rlast.
module tb_iccm_fetch_master;
   localparam int LW = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   always #5 clk = ~clk;
   iccm_fetch_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();
   iccm_fetch_master #(.LINE_WORDS(LW)) dut (.aclk_i(clk), .areset_i(rst), .bus(bus.master));
   typedef struct {logic [31:0] d; logic l; logic e;} word_t;
   word_t q[$];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.req_valid = 0; bus.req_addr = '0; bus.rsp_ready = 0; bus.m_axi_arready = 0;
      bus.m_axi_rvalid = 0; bus.m_axi_rdata = '0; bus.m_axi_rid = '0; bus.m_axi_rlast = 0;
      bus.m_axi_rresp = '0;
   endtask
   task automatic check_reset_outputs();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_last", bus.rsp_last, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_arvalid", bus.m_axi_arvalid, 0);
      chk("rst_rready", bus.m_axi_rready, 0);
      chk("rst_araddr", bus.m_axi_araddr, 0);
   endtask
   // One request: ar_hold = cycles arready stays low, bad_* = beat index carrying that fault
   // (>= LW means none), rsp_stall = initial cycles with rsp_ready low, abort_at = reset after
   // that many beats (0 = never).
   task automatic do_req(input logic [31:0] addr, input int ar_hold, input int bad_resp,
                         input int bad_id, input int bad_last, input int rsp_stall,
                         input bit fast, input int abort_at, input logic [31:0] base);
      int beats = 0, cyc = 0, ar_wait = 0;
      bit ar_done = 0, done = 0, aborted = 0, hold_prev = 0, r_pend = 0;
      logic [31:0] prev_d = '0;
      logic [31:0] exp_addr = addr & ~32'(LW * 4 - 1);
      word_t w;
      q.delete();
      @(negedge clk);
      idle_inputs();
      bus.req_valid = 1; bus.req_addr = addr;
      #1;
      chk("req_ready_idle", bus.req_ready, 1);
      chk("busy_idle", bus.busy, 0);
      while (!done && !aborted && cyc < 500) begin
         @(negedge clk);
         cyc++;
         bus.req_valid = 0; bus.req_addr = $urandom;
         bus.m_axi_arready = !ar_done && ar_wait >= ar_hold;
         if (!ar_done) ar_wait++;
         bus.m_axi_rvalid = ar_done && (r_pend || fast || ($urandom % 4 != 0));
         bus.m_axi_rdata  = base + 32'(beats);
         bus.m_axi_rresp  = (beats == bad_resp) ? 2'b10 : 2'b00;
         bus.m_axi_rid    = (beats == bad_id) ? 4'h3 : 4'h0;
         bus.m_axi_rlast  = (beats == LW - 1) ^ (beats == bad_last);
         bus.rsp_ready    = (cyc <= rsp_stall) ? 1'b0 : (fast || ($urandom % 4 != 0));
         #1;
         chk("busy", bus.busy, 1);
         chk("req_ready_busy", bus.req_ready, 0);
         chk("arvalid", bus.m_axi_arvalid, !ar_done);
         chk("rready", bus.m_axi_rready, ar_done && beats < LW && q.size() < 2);
         chk("rsp_valid", bus.rsp_valid, q.size() != 0);
         if (!ar_done) chk("araddr", bus.m_axi_araddr, exp_addr);
         if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            chk("arlen", bus.m_axi_arlen, LW - 1);
            chk("arburst", bus.m_axi_arburst, 1);
            chk("arsize", bus.m_axi_arsize, 2);
            chk("arid", bus.m_axi_arid, 0);
         end
         if (hold_prev) chk("rsp_hold", bus.rsp_data, prev_d);
         if (q.size() != 0) begin
            chk("rsp_data", bus.rsp_data, q[0].d);
            chk("rsp_last", bus.rsp_last, q[0].l);
            chk("rsp_err", bus.rsp_err, q[0].e);
         end
         hold_prev = bus.rsp_valid && !bus.rsp_ready;
         prev_d    = bus.rsp_data;
         r_pend    = bus.m_axi_rvalid && !bus.m_axi_rready && beats < LW;
         if (bus.rsp_valid && bus.rsp_ready && q.size() != 0) begin
            w = q.pop_front();
            if (w.l) done = 1;
         end
         if (bus.m_axi_rvalid && bus.m_axi_rready && beats < LW) begin
            w.d = base + 32'(beats);
            w.l = beats == LW - 1;
            w.e = beats == bad_resp || beats == bad_id || beats == bad_last;
            q.push_back(w);
            beats++;
         end
         if (bus.m_axi_arvalid && bus.m_axi_arready) ar_done = 1;
         if (abort_at > 0 && beats == abort_at) aborted = 1;
      end
      @(negedge clk);
      if (aborted) begin
         rst = 1;
         idle_inputs();
         #1;
         check_reset_outputs();
         @(negedge clk);
         rst = 0;
      end else begin
         if (!done) chk("line_timeout", 0, 1);
         chk("beats", beats, LW);
         idle_inputs();
         #1;
         chk("end_req_ready", bus.req_ready, 1);
         chk("end_busy", bus.busy, 0);
         chk("end_rsp_valid", bus.rsp_valid, 0);
      end
   endtask
   initial begin
      idle_inputs();
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();
      rst = 0;
      do_req(32'h104, 0, LW, LW, LW, 0, 1, 0, 32'hA0);
      do_req(32'h2C8, 5, LW, LW, LW, 0, 1, 0, 32'hB0);
      do_req(32'h31C, 0, LW, LW, LW, 12, 1, 0, 32'hC0);
      do_req(32'h400, 1, 3, LW, LW, 0, 0, 0, 32'hD0);
      do_req(32'h51F, 0, LW, LW, 5, 0, 0, 0, 32'hE0);
      do_req(32'h600, 0, LW, LW, LW, 0, 1, 5, 32'hF0);
      do_req(32'h7E4, 2, LW, 6, LW, 3, 0, 0, 32'h100);
      for (int i = 0; i < 25; i++)
         do_req($urandom, $urandom_range(0, 4), $urandom_range(0, 11), $urandom_range(0, 11),
                $urandom_range(0, 11), $urandom_range(0, 6), $urandom_range(0, 1),
                ($urandom % 5 == 0) ? $urandom_range(1, LW - 1) : 0, $urandom);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
